// File: rtl/yapp_channel_sink_pkg.sv
// Shared types and header field positions for the YAPP channel sink.
// A header byte is {len[5:0], addr[1:0]}; FIFO entries carry SOP/EOP tags beside the byte.
package yapp_sink_pkg;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } sink_state_e;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
    localparam int BYTE_W   = 8;
    localparam int ENTRY_W  = BYTE_W + 2;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/yapp_channel_sink_if.sv
// Router channel, drained byte stream and scoreboard status for one YAPP sink.
// The slave modport is the sink itself; master is the router/consumer side.
interface yapp_channel_sink_if #(
    parameter int CNT_W = 16
);
    import yapp_sink_pkg::*;

    logic [BYTE_W-1:0] data;
    logic              data_vld;
    logic              suspend;

    logic [BYTE_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_valid;
    logic              out_ready;

    logic              pkt_done;
    logic              parity_err;
    logic              addr_err;
    logic              overflow;
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  err_count;

    modport slave (
        input  data, data_vld, out_ready,
        output suspend, out_data, out_sop, out_eop, out_valid,
        output pkt_done, parity_err, addr_err, overflow, pkt_count, err_count
    );

    modport master (
        output data, data_vld, out_ready,
        input  suspend, out_data, out_sop, out_eop, out_valid,
        input  pkt_done, parity_err, addr_err, overflow, pkt_count, err_count
    );

endinterface

// File: rtl/yapp_channel_sink_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is refused unless a pop
// frees the slot on the same edge. Storage is not reset, only pointers and count.
module yapp_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == FULL_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_en && !pop_en) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/yapp_channel_sink.sv
// YAPP output-channel receiver: frames packets, checks addr/parity, buffers tagged bytes.
//   state   | meaning
//   HDR     | next accepted byte is a header
//   PAYLOAD | cnt_q payload bytes still to come
//   PARITY  | next accepted byte is the parity byte
module yapp_channel_sink
    import yapp_sink_pkg::*;
#(
    parameter logic [1:0] CHANNEL_ID     = 2'd0,
    parameter int         DEPTH          = 64,
    parameter int         SUSPEND_THRESH = DEPTH - 4,
    parameter int         CNT_W          = 16
) (
    input  logic               clock,
    input  logic               reset,
    yapp_channel_sink_if.slave sink_if
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(SUSPEND_THRESH);

    sink_state_e       state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [BYTE_W-1:0] parity_acc_q;
    logic              pkt_bad_q;
    logic              pkt_done_q;
    logic              parity_err_q;
    logic              addr_err_q;
    logic              overflow_q;
    logic              suspend_q, suspend_d;
    logic [CNT_W-1:0]  pkt_count_q;
    logic [CNT_W-1:0]  err_count_q;

    fifo_entry_t       wr_entry;
    fifo_entry_t       rd_entry;
    logic [ENTRY_W-1:0] rd_raw;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic [AW:0]       count_next;
    logic              pop;
    logic              push_ok;
    logic              addr_bad;
    logic              parity_bad;

    assign wr_entry.sop  = (state_q == HDR);
    assign wr_entry.eop  = (state_q == PARITY);
    assign wr_entry.data = sink_if.data;

    assign pop     = !fifo_empty && sink_if.out_ready;
    assign push_ok = sink_if.data_vld && (!fifo_full || pop);

    yapp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (sink_if.data_vld),
        .wdata_i (wr_entry),
        .pop_i   (sink_if.out_ready),
        .rdata_o (rd_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Suspend tracks the occupancy that will exist after this edge, so it lines up with count.
    always_comb begin
        count_next = fifo_count;
        if (push_ok && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = fifo_count - 1'b1;
        end
        suspend_d = (count_next >= THRESH_C);
    end

    assign addr_bad   = (hdr_addr(sink_if.data) != CHANNEL_ID);
    assign parity_bad = (sink_if.data != parity_acc_q);

    // Bytes dropped on overflow still advance the FSM so later headers stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= HDR;
            cnt_q        <= '0;
            parity_acc_q <= '0;
            pkt_bad_q    <= 1'b0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            overflow_q   <= 1'b0;
            suspend_q    <= 1'b0;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            suspend_q    <= suspend_d;
            if (sink_if.data_vld && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (sink_if.data_vld) begin
                case (state_q)
                    HDR: begin
                        parity_acc_q <= sink_if.data;
                        cnt_q        <= hdr_len(sink_if.data);
                        pkt_bad_q    <= addr_bad;
                        addr_err_q   <= addr_bad;
                        state_q      <= (hdr_len(sink_if.data) == '0) ? PARITY : PAYLOAD;
                    end
                    PAYLOAD: begin
                        parity_acc_q <= parity_acc_q ^ sink_if.data;
                        cnt_q        <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        pkt_done_q   <= 1'b1;
                        parity_err_q <= parity_bad;
                        pkt_count_q  <= pkt_count_q + 1'b1;
                        if (parity_bad || pkt_bad_q) begin
                            err_count_q <= err_count_q + 1'b1;
                        end
                        state_q <= HDR;
                    end
                    default: begin
                        state_q <= HDR;
                    end
                endcase
            end
        end
    end

    assign rd_entry = fifo_entry_t'(rd_raw);

    assign sink_if.out_valid  = !fifo_empty;
    assign sink_if.out_data   = fifo_empty ? '0 : rd_entry.data;
    assign sink_if.out_sop    = fifo_empty ? 1'b0 : rd_entry.sop;
    assign sink_if.out_eop    = fifo_empty ? 1'b0 : rd_entry.eop;
    assign sink_if.suspend    = suspend_q;
    assign sink_if.pkt_done   = pkt_done_q;
    assign sink_if.parity_err = parity_err_q;
    assign sink_if.addr_err   = addr_err_q;
    assign sink_if.overflow   = overflow_q;
    assign sink_if.pkt_count  = pkt_count_q;
    assign sink_if.err_count  = err_count_q;

endmodule
